// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port synchronous-read SRAM between the
// instruction-fetch (IFU) and load/store (LSU) requesters. The LSU has fixed
// priority. A starvation counter hands priority to the IFU once it has been
// denied STARVE_LIMIT consecutive cycles. Each response is routed back to its
// owner one cycle after the grant.
module sram_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  input  logic                ifu_kill,
  output logic                ifu_gnt,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req,
  input  logic [DATA_W/8-1:0] lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq,
  output logic [31:0]         conflict_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_q, starve_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_owner_q, pend_owner_d;   // 0 = IFU, 1 = LSU
  logic [31:0] conflict_q, conflict_d;
  logic        ifu_pri;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The IFU takes priority only once it has been starved long enough.
  assign ifu_pri  = (starve_q >= LIMIT);
  assign lsu_gnt  = lsu_req & ~(ifu_req & ifu_pri);
  assign ifu_gnt  = ifu_req & ~lsu_gnt;
  assign stallreq = (ifu_req & ~ifu_gnt) | (lsu_req & ~lsu_gnt);

  // Route the granted requester onto the SRAM port. With no grant, drive zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (lsu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
    end else if (ifu_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = ifu_addr;
    end
  end

  // Next state: starvation run length, conflict count and response owner.
  always_comb begin
    starve_d     = (ifu_req & ~ifu_gnt) ? sat_inc8(starve_q) : 8'd0;
    conflict_d   = (ifu_req & lsu_req) ? sat_inc32(conflict_q) : conflict_q;
    pend_valid_d = ifu_gnt | lsu_gnt;
    pend_owner_d = lsu_gnt;
  end

  // State registers. An asynchronous reset also drops an in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= 8'd0;
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
      conflict_q   <= 32'd0;
    end else begin
      starve_q     <= starve_d;
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
      conflict_q   <= conflict_d;
    end
  end

  // Response return. A kill only masks the IFU response arriving this cycle.
  assign lsu_rvalid   = pend_valid_q & pend_owner_q;
  assign ifu_rvalid   = pend_valid_q & ~pend_owner_q & ~ifu_kill;
  assign lsu_rdata    = lsu_rvalid ? mem_rdata : '0;
  assign ifu_rdata    = ifu_rvalid ? mem_rdata : '0;
  assign conflict_cnt = conflict_q;

endmodule
